time_set_ctrl: RTL

Button-driven time-setting controller for the HH:MM clock: it is the write side of the hours (00–11) and minutes (00–59) BCD counters. It debounces two push-buttons and steps through a set-hours / set-minutes sequence, editing shadow BCD values. While it is active it holds the counters off, then issues a single load strobe with the new values.

---
 rtl/time_set_ctrl_if.sv | 26 ++
 rtl/time_set_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// Bus bundle for the time-setting controller: button and tick inputs,
// current counter values in, shadow values, hold and load strobe out.
interface time_set_ctrl_if;
  logic       i_tick;
  logic       i_btn_mode;
  logic       i_btn_inc;
  logic [7:0] i_hours;
  logic [7:0] i_mins;
  logic       o_hold;
  logic       o_wr;
  logic [7:0] o_hours;
  logic [7:0] o_mins;
  logic [1:0] o_state;

  // Controller side
  modport slave (
    input  i_tick, i_btn_mode, i_btn_inc, i_hours, i_mins,
    output o_hold, o_wr, o_hours, o_mins, o_state
  );

  // Driver side (top level or bench)
  modport master (
    output i_tick, i_btn_mode, i_btn_inc, i_hours, i_mins,
    input  o_hold, o_wr, o_hours, o_mins, o_state
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller for the HH:MM clock. Debounces a mode and an
// increment button, walks RUN -> SET_H -> SET_M -> WRITE, edits shadow BCD
// hours (00-11) and minutes (00-59), holds the counters while editing and
// issues a single load strobe at the end.
// DB_W must be wide enough that 2^DB_W > DB_TICKS.
module time_set_ctrl #(
  parameter int DB_TICKS = 4,
  parameter int DB_W     = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  time_set_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Button index 0 = mode, 1 = inc
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_stable;
  logic [1:0]            r_stable_d;
  logic [DB_W-1:0]       r_cnt [2];
  logic [1:0]            w_evt;
  logic                  w_evt_mode;
  logic                  w_evt_inc;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_load;
  logic                  w_inc_h;
  logic                  w_inc_m;
  logic [7:0]            r_hours;
  logic [7:0]            r_mins;

  // BCD increment of hours with wrap 11 -> 00; anything malformed restarts at 00
  function automatic logic [7:0] inc12(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (hi > 4'd9 || lo > 4'd9 || v >= 8'h11)
      inc12 = 8'h00;
    else if (lo == 4'd9)
      inc12 = {hi + 4'd1, 4'd0};
    else
      inc12 = {hi, lo + 4'd1};
  endfunction

  // BCD increment of minutes with wrap 59 -> 00; anything malformed restarts at 00
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (hi > 4'd9 || lo > 4'd9 || v >= 8'h59)
      inc60 = 8'h00;
    else if (lo == 4'd9)
      inc60 = {hi + 4'd1, 4'd0};
    else
      inc60 = {hi, lo + 4'd1};
  endfunction

  // Two-flop synchroniser for both raw buttons
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {bus.i_btn_inc, bus.i_btn_mode};
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      // Debounce: accept a new level only after DB_TICKS consecutive differing ticks
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt[gi]    <= '0;
          r_stable[gi] <= 1'b0;
        end else if (r_sync2[gi] == r_stable[gi]) begin
          r_cnt[gi] <= '0;
        end else if (bus.i_tick) begin
          if (r_cnt[gi] == DB_W'(DB_TICKS - 1)) begin
            r_stable[gi] <= r_sync2[gi];
            r_cnt[gi]    <= '0;
          end else begin
            r_cnt[gi] <= r_cnt[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Delayed stable level for rising-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_stable_d <= 2'b00;
    else
      r_stable_d <= r_stable;
  end

  // Press event: one cycle after the stable level rises; releases ignored
  assign w_evt      = r_stable & ~r_stable_d;
  assign w_evt_mode = w_evt[0];
  assign w_evt_inc  = w_evt[1];

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state and edit commands; a mode event always wins over inc
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc_h     = 1'b0;
    w_inc_m     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_evt_mode) begin
          w_state_nxt = SET_H;
          w_load      = 1'b1;
        end
      end
      SET_H: begin
        if (w_evt_mode)
          w_state_nxt = SET_M;
        else if (w_evt_inc)
          w_inc_h = 1'b1;
      end
      SET_M: begin
        if (w_evt_mode)
          w_state_nxt = WRITE;
        else if (w_evt_inc)
          w_inc_m = 1'b1;
      end
      WRITE: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Shadow registers: capture on entry to SET_H, then edit in place
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hours <= 8'h00;
      r_mins  <= 8'h00;
    end else if (w_load) begin
      r_hours <= bus.i_hours;
      r_mins  <= bus.i_mins;
    end else if (w_inc_h) begin
      r_hours <= inc12(r_hours);
    end else if (w_inc_m) begin
      r_mins <= inc60(r_mins);
    end
  end

  assign bus.o_hold  = (r_state != RUN);
  assign bus.o_wr    = (r_state == WRITE);
  assign bus.o_state = r_state;
  assign bus.o_hours = r_hours;
  assign bus.o_mins  = r_mins;

endmodule
